// File: rtl/branch_resolve.sv
// Branch/jump resolution: computes the real next PC, compares it with the fetch
// prediction, and drives redirect/flush, link value, misalign flag and statistics.
module branch_resolve #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic             in_taken,
    input  logic             in_pred_taken,
    input  logic [XLEN-1:0]  in_pred_target,
    output logic             redir_valid,
    output logic [XLEN-1:0]  redir_pc,
    input  logic             redir_ack,
    output logic             flush,
    output logic             link_valid,
    output logic [XLEN-1:0]  link_data,
    output logic             misalign,
    output logic [XLEN-1:0]  misalign_addr,
    output logic [CNT_W-1:0] resolved_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    typedef enum logic {
        IDLE,
        REDIRECT
    } state_t;

    state_t          state;
    logic            active;
    logic            taken;
    logic            misaligned;
    logic            mispredict;
    logic            accept;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] next_pc;

    always_comb begin
        // NOTE: every output of this block gets a default up front, so no path can leave one unassigned and infer a latch.
        active     = in_kind != 2'b00;
        taken      = 1'b0;
        seq_pc     = in_pc + XLEN'(4);
        target     = in_pc + in_imm;
        case (in_kind)
            2'b01:   taken = in_taken;
            2'b10:   taken = 1'b1;
            2'b11: begin
                taken     = 1'b1;
                target    = in_rs1 + in_imm;
                target[0] = 1'b0;
            end
            default: taken = 1'b0;
        endcase
        next_pc    = taken ? target : seq_pc;
        misaligned = taken && (target[1:0] != 2'b00);
        mispredict = active && ((taken != in_pred_taken) ||
                                (taken && (target != in_pred_target)));
    end

    // in_ready is a registered copy of (state == IDLE), so it doubles as the accept gate.
    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            in_ready       <= 1'b1;
            redir_valid    <= 1'b0;
            redir_pc       <= '0;
            flush          <= 1'b0;
            link_valid     <= 1'b0;
            link_data      <= '0;
            misalign       <= 1'b0;
            misalign_addr  <= '0;
            resolved_cnt   <= '0;
            mispredict_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            flush      <= 1'b0;
            link_valid <= 1'b0;
            misalign   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && active) begin
                        resolved_cnt <= resolved_cnt + CNT_W'(1);
                        if (misaligned) begin
                            // Trap path: no redirect, no link, not counted as a mispredict.
                            misalign      <= 1'b1;
                            misalign_addr <= target;
                            flush         <= 1'b1;
                        end else begin
                            if (in_kind[1]) begin
                                link_valid <= 1'b1;
                                link_data  <= seq_pc;
                            end
                            if (mispredict) begin
                                redir_valid    <= 1'b1;
                                redir_pc       <= next_pc;
                                flush          <= 1'b1;
                                mispredict_cnt <= mispredict_cnt + CNT_W'(1);
                                in_ready       <= 1'b0;
                                state          <= REDIRECT;
                            end
                        end
                    end
                end
                REDIRECT: begin
                    if (redir_ack) begin
                        redir_valid <= 1'b0;
                        in_ready    <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: driver models the expected response per op,
// monitor compares every cycle; a narrow-counter second instance exercises wrap.
module tb_branch_resolve;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic [1:0]      in_kind = '0;
    logic [XLEN-1:0] in_pc = '0, in_imm = '0, in_rs1 = '0, in_pred_target = '0;
    logic            in_taken = 1'b0, in_pred_taken = 1'b0, redir_ack = 1'b0;

    logic            in_ready, redir_valid, flush, link_valid, misalign;
    logic [XLEN-1:0] redir_pc, link_data, misalign_addr;
    logic [31:0]     resolved_cnt, mispredict_cnt;

    logic            s_in_ready, s_redir_valid, s_flush, s_link_valid, s_misalign;
    logic [XLEN-1:0] s_redir_pc, s_link_data, s_misalign_addr;
    logic [2:0]      s_resolved_cnt, s_mispredict_cnt;

    branch_resolve #(.XLEN(XLEN), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1),
        .in_taken(in_taken), .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ack(redir_ack),
        .flush(flush), .link_valid(link_valid), .link_data(link_data),
        .misalign(misalign), .misalign_addr(misalign_addr),
        .resolved_cnt(resolved_cnt), .mispredict_cnt(mispredict_cnt)
    );

    branch_resolve #(.XLEN(XLEN), .CNT_W(3)) dut_small (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_kind(in_kind), .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1),
        .in_taken(in_taken), .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
        .redir_valid(s_redir_valid), .redir_pc(s_redir_pc), .redir_ack(redir_ack),
        .flush(s_flush), .link_valid(s_link_valid), .link_data(s_link_data),
        .misalign(s_misalign), .misalign_addr(s_misalign_addr),
        .resolved_cnt(s_resolved_cnt), .mispredict_cnt(s_mispredict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            valid;
        logic [1:0]      kind;
        logic [XLEN-1:0] pc, imm, rs1;
        logic            taken, pred_taken;
        logic [XLEN-1:0] pred_target;
    } op_t;

    typedef struct {
        int              due;
        logic            flush, link, mis;
        logic [XLEN-1:0] link_data, mis_addr;
    } exp_t;

    exp_t            exp_q[$];
    exp_t            mon_e;
    int              total = 0, bad = 0, cycle = 0;
    logic            mon_en = 1'b0;
    logic            m_busy = 1'b0;
    logic [XLEN-1:0] m_redir_pc = '0;
    int unsigned     m_res = 0, m_mp = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    function automatic op_t mk(input logic [1:0] kind, input logic [XLEN-1:0] pc, imm, rs1,
                               input logic taken, pt, input logic [XLEN-1:0] ptgt);
        op_t o;
        o.valid = 1'b1; o.kind = kind; o.pc = pc; o.imm = imm; o.rs1 = rs1;
        o.taken = taken; o.pred_taken = pt; o.pred_target = ptgt;
        return o;
    endfunction

    function automatic op_t nop();
        return '{valid: 1'b0, kind: 2'd0, pc: '0, imm: '0, rs1: '0,
                 taken: 1'b0, pred_taken: 1'b0, pred_target: '0};
    endfunction

    // Reference: the architectural branch semantics stated with plain arithmetic.
    function automatic logic ref_taken(input op_t o);
        return (o.kind == 2'd1) ? o.taken : (o.kind != 2'd0);
    endfunction

    function automatic logic [XLEN-1:0] ref_target(input op_t o);
        return (o.kind == 2'd3) ? ((o.rs1 + o.imm) & ~64'd1) : (o.pc + o.imm);
    endfunction

    function automatic op_t rand_op();
        op_t             o;
        logic [31:0]     r;
        r = $urandom;
        o.valid = ($urandom_range(0, 3) != 0);
        o.kind  = 2'($urandom_range(0, 3));
        o.pc    = {$urandom, $urandom} & ~64'd3;
        if ($urandom_range(0, 15) == 0) o.pc = 64'hFFFF_FFFF_FFFF_FF00 | (o.pc & 64'hFC);
        o.imm   = {{52{r[11]}}, r[11:0]};
        o.rs1   = {$urandom, $urandom};
        if ($urandom_range(0, 5) != 0) begin
            o.imm = o.imm & ~64'd3;
            o.rs1 = o.rs1 & ~64'd3;
        end
        o.taken = $urandom_range(0, 1) == 1;
        if ($urandom_range(0, 1) == 1) begin
            o.pred_taken  = ref_taken(o);
            o.pred_target = ref_target(o);
        end else begin
            o.pred_taken  = $urandom_range(0, 1) == 1;
            o.pred_target = ($urandom_range(0, 1) == 1) ? ref_target(o) : {$urandom, $urandom};
        end
        return o;
    endfunction

    // Drives one cycle of stimulus; the expected response is queued at the edge.
    task automatic step(input op_t o, input logic ack, output logic acc);
        logic            t, mis, mp;
        logic [XLEN-1:0] tgt, npc;
        exp_t            e;
        in_valid = o.valid; in_kind = o.kind; in_pc = o.pc; in_imm = o.imm; in_rs1 = o.rs1;
        in_taken = o.taken; in_pred_taken = o.pred_taken; in_pred_target = o.pred_target;
        redir_ack = ack;
        acc = o.valid && !m_busy;
        t   = ref_taken(o);
        tgt = ref_target(o);
        npc = t ? tgt : o.pc + 64'd4;
        mis = t && (tgt % 4 != 0);
        mp  = (t != o.pred_taken) || (t && tgt != o.pred_target);
        e.flush = mis || mp; e.link = (o.kind >= 2'd2) && !mis; e.mis = mis;
        e.link_data = o.pc + 64'd4; e.mis_addr = tgt; e.due = 0;
        @(posedge clk);
        cycle++;
        if (m_busy && ack) begin
            m_busy = 1'b0;
        end else if (acc && o.kind != 2'd0) begin
            m_res++;
            if (!mis && mp) begin
                m_busy = 1'b1; m_redir_pc = npc; m_mp++;
            end
            if (e.flush || e.link) begin
                e.due = cycle;
                exp_q.push_back(e);
            end
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_e = '{due: 0, flush: 1'b0, link: 1'b0, mis: 1'b0, link_data: '0, mis_addr: '0};
            if (exp_q.size() > 0 && exp_q[0].due == cycle) mon_e = exp_q.pop_front();
            check("in_ready", 64'(in_ready), 64'(!m_busy));
            check("redir_valid", 64'(redir_valid), 64'(m_busy));
            check("flush", 64'(flush), 64'(mon_e.flush));
            check("link_valid", 64'(link_valid), 64'(mon_e.link));
            check("misalign", 64'(misalign), 64'(mon_e.mis));
            if (mon_e.link) check("link_data", link_data, mon_e.link_data);
            if (mon_e.mis) check("misalign_addr", misalign_addr, mon_e.mis_addr);
            if (m_busy) check("redir_pc", redir_pc, m_redir_pc);
            check("resolved_cnt", 64'(resolved_cnt), 64'(m_res));
            check("mispredict_cnt", 64'(mispredict_cnt), 64'(m_mp));
            check("small_resolved_cnt", 64'(s_resolved_cnt), 64'(m_res % 8));
            check("small_mispredict_cnt", 64'(s_mispredict_cnt), 64'(m_mp % 8));
            check("small_redir_valid", 64'(s_redir_valid), 64'(m_busy));
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_redir_valid"}, 64'(redir_valid), 64'd0);
        check({tag, "_redir_pc"}, redir_pc, 64'd0);
        check({tag, "_flush"}, 64'(flush), 64'd0);
        check({tag, "_link"}, 64'(link_valid) | link_data, 64'd0);
        check({tag, "_misalign"}, 64'(misalign) | misalign_addr, 64'd0);
        check({tag, "_counters"}, 64'(resolved_cnt) | 64'(mispredict_cnt), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic acc;
        op_t  cur;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Correctly predicted not-taken, then a mispredicted taken branch held for 3 cycles.
        step(mk(2'd1, 64'h1000, 64'h40, 64'h0, 1'b0, 1'b0, 64'h0), 1'b0, acc);
        step(nop(), 1'b0, acc);
        step(mk(2'd1, 64'h1000, 64'h40, 64'h0, 1'b1, 1'b0, 64'h0), 1'b0, acc);
        check("redirect_pc_0x1040", redir_pc, 64'h1040);
        cur = mk(2'd2, 64'h100, 64'h20, 64'h0, 1'b0, 1'b1, 64'h120);
        repeat (3) step(cur, 1'b0, acc);
        step(cur, 1'b1, acc);
        step(cur, 1'b0, acc);
        check("jal_link_0x104", link_data, 64'h104);

        // JALR: misaligned target, then aligned wrong target with link.
        step(mk(2'd3, 64'h500, 64'h4, 64'h2003, 1'b0, 1'b1, 64'h2000), 1'b0, acc);
        check("jalr_misalign_addr", misalign_addr, 64'h2006);
        step(mk(2'd3, 64'h500, 64'h4, 64'h2001, 1'b0, 1'b1, 64'h2000), 1'b0, acc);
        check("jalr_redirect_0x2004", redir_pc, 64'h2004);
        step(nop(), 1'b1, acc);

        // Sequential PC wrap-around and ack while idle.
        step(mk(2'd1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h40, 64'h0, 1'b0, 1'b1, 64'h0), 1'b0, acc);
        check("wrap_redirect_0", redir_pc, 64'h0);
        step(nop(), 1'b1, acc);
        repeat (2) step(nop(), 1'b1, acc);

        // Back-to-back correct predictions.
        for (int i = 0; i < 6; i++) begin
            cur = mk(2'd1, 64'h4000 + 64'(i * 8), 64'h10, 64'h0, 1'(i % 2), 1'(i % 2),
                     64'h4010 + 64'(i * 8));
            step(cur, 1'b0, acc);
            check("b2b_accept", 64'(acc), 64'd1);
        end

        // Reset asserted while a redirect is pending.
        step(mk(2'd1, 64'h3000, 64'h80, 64'h0, 1'b1, 1'b0, 64'h0), 1'b0, acc);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        m_busy = 1'b0; m_res = 0; m_mp = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        step(mk(2'd2, 64'h200, 64'h40, 64'h0, 1'b0, 1'b0, 64'h0), 1'b0, acc);
        check("post_reset_accept", 64'(acc), 64'd1);
        step(nop(), 1'b1, acc);

        // Randomized traffic with held ops while a redirect is outstanding.
        cur = rand_op();
        for (int i = 0; i < 600; i++) begin
            step(cur, m_busy && ($urandom_range(0, 2) == 0), acc);
            if (acc || !cur.valid) cur = rand_op();
        end
        repeat (3) step(nop(), 1'b1, acc);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
